// File: rtl/conv_pkg.sv
// conv_pkg: shared types for the streaming 3x3 convolution frame sequencer.
// Sequencer FSM encoding and the default-sized window-centre tag.
package conv_pkg;

  localparam int DEF_ROW_SIZE     = 540;
  localparam int DEF_IMAGE_HEIGHT = 360;
  localparam int ROW_W = $clog2(DEF_IMAGE_HEIGHT);
  localparam int COL_W = $clog2(DEF_ROW_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } conv_seq_state_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } conv_tag_t;

endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: DEPTH-stage free-running shift register of window tags.
// Ports: clk, rst (sync clear), tag_i (pushed every cycle), tag_o (head).
module conv_tag_pipe
  import conv_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type tag_t = conv_tag_t
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: frame controller for the 3x3 convolution datapath.
// Ports: clk/rst, start/busy/frame_done, in_* source handshake,
// conv_* datapath drive, out_* tagged results (row/col window centre).
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int WORD_SIZE      = 8,
  parameter int ROW_SIZE       = 540,
  parameter int IMAGE_HEIGHT   = 360,
  parameter int KERNEL_SIZE    = 3,
  parameter int PIPE_LAT       = 2,
  parameter int SCAN_BOTTOM_UP = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            frame_done,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_SIZE-1:0]            in_pixel,
  output logic                            conv_clr,
  output logic                            conv_en,
  output logic [WORD_SIZE-1:0]            conv_pixel,
  input  logic [WORD_SIZE-1:0]            conv_result,
  output logic                            out_valid,
  output logic [WORD_SIZE-1:0]            out_pixel,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] out_row,
  output logic [$clog2(ROW_SIZE)-1:0]     out_col
);

  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int CW = $clog2(ROW_SIZE);
  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [RW-1:0] K_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] K_MIN  = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(KERNEL_SIZE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } tag_t;

  conv_seq_state_t state_q, state_d;
  logic [RW-1:0]   k_q, k_d;
  logic [CW-1:0]   c_q, c_d;
  logic [DW-1:0]   drain_q, drain_d;

  logic          xfer;
  logic [RW-1:0] k_m1;
  tag_t          tag_in;
  tag_t          tag_out;

  assign in_ready   = (state_q == STREAM);
  assign xfer       = in_valid & in_ready;
  assign conv_en    = xfer;
  assign conv_pixel = in_pixel;
  assign busy       = (state_q == STREAM) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    c_d      = c_q;
    drain_d  = drain_q;
    conv_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          k_d      = '0;
          c_d      = '0;
          // a start coinciding with rst must not clear the datapath
          conv_clr = !rst;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (c_q == C_LAST) begin
            c_d = '0;
            k_d = k_q + RW'(1);
            if (k_q == K_LAST) begin
              state_d = DRAIN;
              k_d     = '0;
              drain_d = '0;
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // centre lags the scan position by one row and one column;
  // wrap-around at k=0/c=0 is harmless since valid is low there
  assign k_m1 = k_q - RW'(1);

  always_comb begin
    tag_in       = '0;
    tag_in.valid = xfer && (k_q >= K_MIN) && (c_q >= C_MIN);
    tag_in.row   = (SCAN_BOTTOM_UP != 0) ? (K_LAST - k_m1) : k_m1;
    tag_in.col   = c_q - CW'(1);
  end

  conv_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .tag_t (tag_t)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign out_valid = tag_out.valid;
  assign out_row   = tag_out.row;
  assign out_col   = tag_out.col;
  assign out_pixel = conv_result;

endmodule
